// File: rtl/lsu_if.sv
// Request/response bus between a CPU pipeline and the load/store unit.
// The CPU side is the master; the load/store unit is the slave.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V style load/store unit in front of a word-wide internal data array.
// One request is handled at a time: IDLE accepts, READ fetches the word,
// WRITE stores (full word or read-modify-write of byte/half lanes), and
// RESP emits a single-cycle completion pulse.
module load_store_unit #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t          state_reg, state_next;
  logic            we_reg;
  logic [AW+1:0]   addr_reg;
  logic [2:0]      funct3_reg;
  logic [31:0]     wdata_reg;
  logic            err_reg;

  // Data array has no reset: it relies on power-up zero contents and must
  // survive rst_n so that stored data outlives an aborted request.
  logic [31:0]     mem [DEPTH_WORDS];
  logic [31:0]     rd_word_reg;
  logic [31:0]     merged_word;
  logic [31:0]     shifted_word;
  logic [31:0]     load_data;
  logic            accept;
  logic            req_err;

  assign accept = bus.req_valid && (state_reg == IDLE);

  // Classify the incoming request as rejected (range, alignment, funct3).
  always_comb begin
    req_err = 1'b0;
    if (bus.req_addr >= ADDR_LIMIT) req_err = 1'b1;
    if (bus.req_we) begin
      if (bus.req_funct3 >= 3'b011) req_err = 1'b1;
    end else if (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 ||
                 bus.req_funct3 == 3'b111) begin
      req_err = 1'b1;
    end
    if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])          req_err = 1'b1;
    if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
  end

  // State register; reset drops straight back to IDLE, aborting any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_err)                                    state_next = RESP;
          else if (bus.req_we && bus.req_funct3 == 3'b010) state_next = WRITE;
          else                                            state_next = READ;
        end
      end
      READ:    state_next = we_reg ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the request at accept so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      funct3_reg <= 3'b000;
      wdata_reg  <= 32'h0;
      err_reg    <= 1'b0;
    end else if (accept) begin
      we_reg     <= bus.req_we;
      addr_reg   <= bus.req_addr[AW+1:0];
      funct3_reg <= bus.req_funct3;
      wdata_reg  <= bus.req_wdata;
      err_reg    <= req_err;
    end
  end

  // Registered array read, used by loads and by sub-word stores.
  always_ff @(posedge clk) begin
    if (state_reg == READ) rd_word_reg <= mem[addr_reg[AW+1:2]];
  end

  // Array write. Only reachable from WRITE, which the async reset vacates,
  // so an aborted or errored request never touches the array.
  always_ff @(posedge clk) begin
    if (state_reg == WRITE) mem[addr_reg[AW+1:2]] <= merged_word;
  end

  // Per-byte-lane merge of store data into the fetched word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       lane_en;
    logic [7:0] lane_src;

    // Select whether this lane is overwritten and from which store byte.
    always_comb begin
      lane_en  = 1'b0;
      lane_src = wdata_reg[7:0];
      case (funct3_reg[1:0])
        2'b10: begin
          lane_en  = 1'b1;
          lane_src = wdata_reg[8*gi +: 8];
        end
        2'b01: begin
          lane_en  = (addr_reg[1] == LANE[1]);
          lane_src = wdata_reg[8*(gi%2) +: 8];
        end
        default: lane_en = (addr_reg[1:0] == LANE);
      endcase
    end

    assign merged_word[8*gi +: 8] = lane_en ? lane_src : rd_word_reg[8*gi +: 8];
  end

  assign shifted_word = rd_word_reg >> {addr_reg[1:0], 3'b000};

  // Extract and extend the addressed byte/half, or pass the full word.
  always_comb begin
    load_data = shifted_word;
    case (funct3_reg)
      3'b000:  load_data = {{24{shifted_word[7]}},  shifted_word[7:0]};
      3'b001:  load_data = {{16{shifted_word[15]}}, shifted_word[15:0]};
      3'b100:  load_data = {24'h0, shifted_word[7:0]};
      3'b101:  load_data = {16'h0, shifted_word[15:0]};
      default: load_data = shifted_word;
    endcase
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_err   = (state_reg == RESP) && err_reg;
  assign bus.rsp_rdata = ((state_reg == RESP) && !err_reg && !we_reg) ? load_data : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic, checked against a byte-level reference memory model.
module tb_load_store_unit;

  localparam int DEPTH = 64;

  logic clk;
  logic rst_n;
  lsu_if bus ();

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          acc_cyc;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: applies one request to ref_mem, returns expected outcome.
  task automatic model_req(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] wd, output logic err,
                           output logic [31:0] rd, output int lat);
    logic [31:0] word;
    logic [31:0] v;
    int          sh;
    err = (addr >= 32'(DEPTH * 4)) ||
          ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) ||
          (f3 == 3'd2 && addr[1:0] != 2'b00) ||
          (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
          (we && f3 >= 3'd3);
    rd  = 32'h0;
    lat = 1;
    if (!err) begin
      word = ref_mem[addr[7:2]];
      sh   = int'(addr[1:0]) * 8;
      v    = word >> sh;
      if (we) begin
        if (f3 == 3'd2) begin
          ref_mem[addr[7:2]] = wd;
          lat = 2;
        end else if (f3 == 3'd0) begin
          ref_mem[addr[7:2]] = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
          lat = 3;
        end else begin
          ref_mem[addr[7:2]] = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
          lat = 3;
        end
      end else begin
        lat = 2;
        case (f3)
          3'd0: begin rd = v & 32'hFF;   if (rd >= 32'h80)   rd = rd | 32'hFFFFFF00; end
          3'd1: begin rd = v & 32'hFFFF; if (rd >= 32'h8000) rd = rd | 32'hFFFF0000; end
          3'd4: rd = v & 32'hFF;
          3'd5: rd = v & 32'hFFFF;
          default: rd = word;
        endcase
      end
    end
  endtask

  // One complete transaction: drive, accept, scramble inputs, await response.
  task automatic xact(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] wd, input string tag, input bit no_wait);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          lat;
    bit          got;
    logic [31:0] got_rd;
    logic        got_err;
    model_req(we, addr, f3, wd, exp_err, exp_rd, exp_lat);
    if (!no_wait) @(negedge clk);
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_no_stale_rsp"}, 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_addr   = $urandom;
    bus.req_funct3 = 3'($urandom);
    bus.req_wdata  = $urandom;
    got = 1'b0; lat = 0; got_rd = 32'h0; got_err = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1; lat = k; got_rd = bus.rsp_rdata; got_err = bus.rsp_err;
        chk({tag, "_busy_in_resp"}, 32'(bus.req_ready), 32'd0);
      end else begin
        chk({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_idle_rdata"}, bus.rsp_rdata, 32'h0);
        chk({tag, "_idle_err"}, 32'(bus.rsp_err), 32'd0);
      end
    end
    chk({tag, "_got_rsp"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(got_err), 32'(exp_err));
    chk({tag, "_rdata"}, got_rd, exp_rd);
    $display("xact %s we=%0d addr=%h f3=%0d wdata=%h -> lat=%0d err=%0d rdata=%h",
             tag, we, addr, f3, wd, lat, got_err, got_rd);
  endtask

  initial begin
    exp_t        q[$];
    exp_t        e;
    logic        m_err;
    logic [31:0] m_rd;
    int          m_lat;
    bit          outstanding;
    int          acc_cnt;
    int          rsp_cnt;
    int          op_idx;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_funct3 = 3'b000;
    bus.req_wdata  = 32'h0;
    rst_n = 1'b0;
    #1;
    chk("reset_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Bring the array to a known all-zero state.
    for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i * 4), 3'd2, 32'h0, "clear", 1'b0);

    // Word store/load.
    xact(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, "sw_10", 1'b0);
    xact(1'b0, 32'h10, 3'd2, 32'h0, "lw_10", 1'b0);
    // Byte store with read-modify-write.
    xact(1'b1, 32'h13, 3'd0, 32'h00000080, "sb_13", 1'b0);
    xact(1'b0, 32'h13, 3'd0, 32'h0, "lb_13", 1'b0);
    xact(1'b0, 32'h13, 3'd4, 32'h0, "lbu_13", 1'b0);
    xact(1'b0, 32'h10, 3'd2, 32'h0, "lw_10_b", 1'b0);
    // Half store.
    xact(1'b1, 32'h12, 3'd1, 32'h00001234, "sh_12", 1'b0);
    xact(1'b0, 32'h12, 3'd5, 32'h0, "lhu_12", 1'b0);
    xact(1'b0, 32'h10, 3'd1, 32'h0, "lh_10", 1'b0);
    xact(1'b0, 32'h10, 3'd2, 32'h0, "lw_10_c", 1'b0);
    // Rejected requests.
    xact(1'b0, 32'h11, 3'd2, 32'h0, "err_lw_11", 1'b0);
    xact(1'b1, 32'h13, 3'd1, 32'hFFFFFFFF, "err_sh_13", 1'b0);
    xact(1'b0, 32'h100, 3'd2, 32'h0, "err_lw_100", 1'b0);
    xact(1'b0, 32'h10, 3'd3, 32'h0, "err_f3_011", 1'b0);
    xact(1'b1, 32'h10, 3'd3, 32'hFFFFFFFF, "err_st_f3", 1'b0);
    xact(1'b0, 32'h10, 3'd2, 32'h0, "lw_10_d", 1'b0);

    // Reset pulse while sb 0xFF @0x10 sits in WRITE.
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_addr = 32'h10; bus.req_funct3 = 3'd0;
    bus.req_wdata = 32'hFF; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("abort_rsp_rdata", bus.rsp_rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    // First edge after reset release must accept.
    xact(1'b0, 32'h10, 3'd2, 32'h0, "lw_after_abort", 1'b1);

    // Back-to-back stream with req_valid held high, alternating sw/lw @0x20.
    outstanding = 1'b0; acc_cnt = 0; rsp_cnt = 0; op_idx = 0;
    for (int cyc = 0; cyc < 28; cyc++) begin
      @(negedge clk);
      chk("stream_ready", 32'(bus.req_ready), 32'(!outstanding));
      if (bus.rsp_valid) begin
        chk("stream_rsp_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("stream_rdata", bus.rsp_rdata, e.rd);
          chk("stream_err", 32'(bus.rsp_err), 32'(e.err));
          chk("stream_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
          $display("xact stream rsp cyc=%0d rdata=%h err=%0d", cyc, bus.rsp_rdata, bus.rsp_err);
        end
        outstanding = 1'b0;
        rsp_cnt++;
      end else begin
        chk("stream_idle_rdata", bus.rsp_rdata, 32'h0);
      end
      if (cyc < 20) begin
        bus.req_we     = (op_idx % 2 == 0);
        bus.req_addr   = 32'h20;
        bus.req_funct3 = 3'd2;
        bus.req_wdata  = $urandom;
        bus.req_valid  = 1'b1;
        if (bus.req_ready) begin
          model_req(bus.req_we, bus.req_addr, bus.req_funct3, bus.req_wdata, m_err, m_rd, m_lat);
          e.err = m_err; e.rd = m_rd; e.lat = m_lat; e.acc_cyc = cyc;
          q.push_back(e);
          outstanding = 1'b1;
          acc_cnt++;
          op_idx++;
        end
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    chk("stream_rsp_count", 32'(rsp_cnt), 32'(acc_cnt));
    chk("stream_min_accepts", 32'(acc_cnt >= 5), 32'd1);

    // Random traffic, a mix of legal and rejected requests.
    for (int i = 0; i < 48; i++) begin
      logic [31:0] a;
      logic [2:0]  f;
      bit          w;
      w = 1'($urandom);
      f = 3'($urandom);
      if ($urandom_range(0, 7) == 0) a = 32'h100 + 32'($urandom_range(0, 15));
      else                           a = 32'($urandom_range(0, DEPTH * 4 - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (f[1:0] == 2'b01) a[0] = 1'b0;
        if (f[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      xact(w, a, f, $urandom, "rand", 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DEPTH_WORDS, 64, number of 32-bit words in the internal data array; legal byte addresses are 0 .. DEPTH_WORDS*4-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  CPU presents a memory request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_funct3  input  3  RISC-V funct3: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw.
REQ-009 req_wdata  input  32  store data; byte/half taken from low bits.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  load result, extended to 32 bits.
REQ-012 rsp_err  output  1  request rejected (misaligned, out of range, illegal funct3).

Function
REQ-013 The unit SHALL use the FSM states IDLE, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_we, req_addr, req_funct3 and req_wdata SHALL be latched then, and later input changes SHALL have no effect.
REQ-015 Error at accept: lh/lhu/sh with addr[0]!=0; lw/sw with addr[1:0]!=0; addr >= DEPTH_WORDS*4; load funct3 in {011,110,111}; store funct3 >= 011.
REQ-016 Transitions from IDLE on accept: error -> RESP; sw -> WRITE; all other requests -> READ.
REQ-017 READ: on the edge, register array word addr[log2(DEPTH_WORDS)+1:2]; load -> RESP, sb/sh -> WRITE.
REQ-018 WRITE: on the edge, write the word. For sw, write the full req_wdata. For sb/sh, write the read word with only the addressed lane(s) replaced (read-modify-write). Then go to RESP.
REQ-019 RESP: rsp_valid=1 for exactly one cycle, then IDLE; no response backpressure.
REQ-020 Latency from the accept edge to the rsp_valid cycle: error 1 cycle; sw 2 cycles; load 2 cycles; sb/sh 3 cycles.
REQ-021 Byte order is little-endian: byte lane = addr[1:0], half lane = addr[1] (bits 31:16 when 1).
REQ-022 Load data: lb/lh sign-extend; lbu/lhu zero-extend; lw returns the word unchanged.
REQ-023 rsp_rdata SHALL be 0 when rsp_valid=0, for stores, and for errors; rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-024 An errored request SHALL never modify the array.
REQ-025 With req_valid held high continuously, exactly one response SHALL occur per accepted request, and no request SHALL be accepted outside IDLE.
REQ-026 The array SHALL initialise to all zeros at simulation start and SHALL NOT be cleared by reset.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, req_ready=1, rsp_valid=0, rsp_err=0 and rsp_rdata=0, regardless of clk.
REQ-028 Reset during READ or WRITE SHALL abort the request: no array write and no response are produced.
REQ-029 After rst_n deasserts, a request can be accepted on the first rising edge.

Verification
REQ-030 sw 0xDEADBEEF @0x10, then lw @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; the sw response is 2 cycles after accept and the lw response 2 cycles after accept.
REQ-031 sb 0x80 @0x13 (response 3 cycles after accept) -> lb @0x13 = 0xFFFFFF80; lbu @0x13 = 0x00000080; lw @0x10 = 0x80ADBEEF.
REQ-032 sh 0x1234 @0x12 -> lhu @0x12 = 0x00001234; lh @0x10 = 0xFFFFBEEF; lw @0x10 = 0x1234BEEF.
REQ-033 Each of the following SHALL give rsp_err=1 and rsp_rdata=0 one cycle after accept: lw @0x11, sh @0x13, lw @0x100, load funct3=011. A following lw @0x10 SHALL still return 0x1234BEEF.
REQ-034 Pulse rst_n low in WRITE of sb 0xFF @0x10 -> req_ready=1 at once, no rsp_valid, and lw @0x10 still returns 0x1234BEEF.
REQ-035 Hold req_valid=1 for 20 cycles with alternating sw/lw @0x20 -> req_ready low in every non-IDLE cycle, one rsp_valid per accept, and each lw returns the preceding sw data.
